divider2: RTL and testbench
===========================

# divider2

Sequential unsigned 16÷8 restoring divider, the inverse unit of the 8×8 shift-add multiplier in the arithmetic project. It sits beside `multiplier2` and uses the same `start`/`ready` handshake. It takes a 16-bit dividend and an 8-bit divisor and produces an 8-bit quotient and an 8-bit remainder after 8 iteration cycles. Divide-by-zero and quotient overflow are flagged instead of computed.

## Interface
- `N`, default 8: divisor/quotient/remainder width. The dividend is 2N. The bench and the integration use only N=8.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous reset, active low. Asserting it clears all state immediately.
- `start`  input  1  request, sampled on a rising edge only while `ready`=1.
- `Dividend`  input  16  unsigned dividend, captured on the accepting edge.
- `Divisor`  input  8  unsigned divisor, captured on the accepting edge.
- `Quotient`  output  8  result quotient. Registered. Valid while `ready`=1 after a completed operation.
- `Remainder`  output  8  result remainder. Registered. Same validity as `Quotient`.
- `error`  output  1  last operation was divide-by-zero or quotient overflow.
- `ready`  output  1  high = idle with results valid; low = busy.

## Operation
- States:
  - IDLE: `ready`=1.
  - CALC: `ready`=0, 3-bit step counter.
  - FAULT: `ready`=0, lasts one cycle.
- Reset values: state IDLE, `ready`=1, `Quotient`=0, `Remainder`=0, `error`=0, counter 0.
- Accept in IDLE, on an edge with `start`=1:
  - Latch the divisor into D.
  - Load R (9 bits) = {0, `Dividend[15:8]`}.
  - Load Q (8 bits) = `Dividend[7:0]`.
  - Clear `error`.
- Fault check at the accepting edge:
  - Fault when `Divisor`=0, or `Dividend[15:8]` ≥ `Divisor` (the quotient would not fit in 8 bits).
  - On fault, go to FAULT. Otherwise go to CALC with counter=0.
- CALC step, once per edge:
  - Shift {R,Q} left by 1, then compare R with D.
  - If R ≥ D: R = R − D and Q[0] = 1. Otherwise Q[0] = 0.
  - Counter +1. After the 8th step, go to IDLE.
- Completion:
  - `Quotient` = Q and `Remainder` = R[7:0], both updated on the edge that enters IDLE.
  - R < D always holds, so `Remainder` fits in 8 bits.
- FAULT: the next edge goes to IDLE with `error`=1, `Quotient`=8'hFF, `Remainder`=8'hFF.
- `start` while busy is ignored; no queuing.
- Operand inputs are don't-care outside the accepting edge, so X on them must not corrupt results.
- `Quotient`, `Remainder` and `error` hold their values in IDLE until the next completion. They are not cleared on accept, only their validity (`ready`) drops.
- Invariant for every non-fault input: Dividend = Quotient·Divisor + Remainder.

## Timing
- Edge 0 accepts `start`, and `ready` falls after edge 0.
- The normal path completes at edge 8: `ready` rises and results are visible after edge 8. Latency is 8 cycles from the accepting edge.
- The fault path completes at edge 1 (1-cycle latency).
- `start` held high across completion is accepted at the first edge with `ready`=1, i.e. edge 9. This gives back-to-back throughput of 9 cycles per operation.
- The bench waits 10 edges after `start`; both paths have finished by then.
- `rst_n` low mid-operation aborts at once: outputs return to reset values and `ready`=1 asynchronously. The first edge after release can accept a new `start`.
- No combinational path from inputs to outputs.

## Test plan
- Reset then idle: `rst_n`=0 → `ready`=1, `Quotient`=0, `Remainder`=0, `error`=0. Hold `start`=0 for 5 cycles → outputs unchanged.
- Nominal: 16'h03E8 (1000) ÷ 8'h07 → 8 cycles later `Quotient`=8'h8E (142), `Remainder`=8'h06, `error`=0. `ready` is low for exactly 8 cycles.
- Boundary: 16'hFEFF ÷ 8'hFF → `Quotient`=8'hFF, `Remainder`=8'hFE, `error`=0. Also 16'h0000 ÷ 8'h01 → 0 / 0.
- Faults:
  - 16'h1234 ÷ 8'h00 → after 1 cycle `error`=1, `Quotient`=8'hFF, `Remainder`=8'hFF.
  - 16'h0800 ÷ 8'h08 → same fault response.
  - The next valid operation clears `error`.
- Busy/abort:
  - Pulse `start` with new operands 3 cycles into a division → ignored; the original result is produced.
  - `rst_n` low at cycle 4 of 16'h03E8÷7 → immediate reset values.
  - 16'h0064 ÷ 8'h0A after release → 8'h0A / 8'h00.
- Random: 100 random pairs with `Dividend[15:8]` < `Divisor`, `Divisor`≠0, and operands driven to X after the accepting edge → the results match `/` and `%` exactly. Print OK/ERROR per test and count the errors.

Source files
------------

// File: rtl/divider2_if.sv
// Handshake and operand/result bundle for the sequential 16/8 restoring divider.
// The master drives the request and operands; the slave (divider2) returns results.
interface divider2_if #(parameter int N = 8);
   logic           start;
   logic [2*N-1:0] Dividend;
   logic [N-1:0]   Divisor;
   logic [N-1:0]   Quotient;
   logic [N-1:0]   Remainder;
   logic           error;
   logic           ready;

   modport master (
      output start, Dividend, Divisor,
      input  Quotient, Remainder, error, ready
   );

   modport slave (
      input  start, Dividend, Divisor,
      output Quotient, Remainder, error, ready
   );
endinterface

// File: rtl/divider2.sv
// Sequential unsigned 2N/N restoring divider with start/ready handshake.
// One quotient bit per cycle; divide-by-zero and quotient overflow are flagged.
module divider2 #(
   parameter int N = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   divider2_if.slave  bus
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t        state_r;
   // R < D always holds between steps, so only N bits of R need storing;
   // the ninth bit appears only in the shifted value.
   logic [N-1:0]  rem_r;
   logic [N-1:0]  quo_r;
   logic [N-1:0]  div_r;
   logic [CW-1:0] cnt_r;
   logic [N-1:0]  quotient_r;
   logic [N-1:0]  remainder_r;
   logic          error_r;
   logic          ready_r;

   logic [N:0]    rem_sh_s;
   logic [N:0]    diff_s;
   logic [N-1:0]  rem_s;
   logic [N-1:0]  quo_s;
   logic          fault_s;

   // Fault detection on the operands presented at the accepting edge.
   always_comb begin
      fault_s = (bus.Divisor == {N{1'b0}}) || (bus.Dividend[2*N-1:N] >= bus.Divisor);
   end

   // One restoring step: shift {R,Q} left, trial-subtract D, restore on borrow.
   always_comb begin
      rem_sh_s = {rem_r, quo_r[N-1]};
      diff_s   = rem_sh_s - {1'b0, div_r};
      if (!diff_s[N]) begin
         rem_s = diff_s[N-1:0];
         quo_s = {quo_r[N-2:0], 1'b1};
      end else begin
         rem_s = rem_sh_s[N-1:0];
         quo_s = {quo_r[N-2:0], 1'b0};
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         rem_r       <= {N{1'b0}};
         quo_r       <= {N{1'b0}};
         div_r       <= {N{1'b0}};
         cnt_r       <= {CW{1'b0}};
         quotient_r  <= {N{1'b0}};
         remainder_r <= {N{1'b0}};
         error_r     <= 1'b0;
         ready_r     <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  div_r   <= bus.Divisor;
                  rem_r   <= bus.Dividend[2*N-1:N];
                  quo_r   <= bus.Dividend[N-1:0];
                  cnt_r   <= {CW{1'b0}};
                  error_r <= 1'b0;
                  ready_r <= 1'b0;
                  state_r <= fault_s ? FAULT : CALC;
               end
            end
            CALC: begin
               rem_r <= rem_s;
               quo_r <= quo_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CW'(N - 1)) begin
                  quotient_r  <= quo_s;
                  remainder_r <= rem_s;
                  ready_r     <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            FAULT: begin
               quotient_r  <= {N{1'b1}};
               remainder_r <= {N{1'b1}};
               error_r     <= 1'b1;
               ready_r     <= 1'b1;
               state_r     <= IDLE;
            end
            default: begin
               ready_r <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.Quotient  = quotient_r;
   assign bus.Remainder = remainder_r;
   assign bus.error     = error_r;
   assign bus.ready     = ready_r;

endmodule

// File: tb/tb_divider2.sv
// Directed and random self-checking bench for divider2 (N=8).
module tb_divider2;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   divider2_if #(.N(8)) bus ();

   divider2 #(.N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one operation and count negedges after the accepting edge until ready.
   task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.Dividend = dvd;
      bus.Divisor  = dvs;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.Dividend = {16{1'bx}};
      bus.Divisor  = {8{1'bx}};
      lat = 0;
      while (bus.ready !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      bus.start    = 1'b0;
      bus.Dividend = 16'h0000;
      bus.Divisor  = 8'h00;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (bus.ready !== 1'b1 || bus.Quotient !== 8'h00 || bus.Remainder !== 8'h00 || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL reset: got rdy=%b q=%h r=%h err=%b want 1 00 00 0",
                  bus.ready, bus.Quotient, bus.Remainder, bus.error);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if (bus.ready !== 1'b1 || bus.Quotient !== 8'h00 || bus.Remainder !== 8'h00 || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL idle_hold: got rdy=%b q=%h r=%h err=%b want 1 00 00 0",
                  bus.ready, bus.Quotient, bus.Remainder, bus.error);
      end
   endtask

   task automatic test_nominal;
      int lat;
      run_op(16'h03E8, 8'h07, lat);
      total++;
      if (lat !== 8) begin
         bad++;
         $display("FAIL nominal_latency: got %0d want 8", lat);
      end
      total++;
      if (bus.Quotient !== 8'h8E || bus.Remainder !== 8'h06 || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL nominal: got q=%h r=%h err=%b want 8e 06 0", bus.Quotient, bus.Remainder, bus.error);
      end
      repeat (3) @(negedge clk);
      total++;
      if (bus.Quotient !== 8'h8E || bus.Remainder !== 8'h06 || bus.ready !== 1'b1) begin
         bad++;
         $display("FAIL nominal_hold: got q=%h r=%h rdy=%b want 8e 06 1", bus.Quotient, bus.Remainder, bus.ready);
      end
   endtask

   task automatic test_boundary;
      int lat;
      run_op(16'hFEFF, 8'hFF, lat);
      total++;
      if (lat !== 8 || bus.Quotient !== 8'hFF || bus.Remainder !== 8'hFE || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL boundary_max: got lat=%0d q=%h r=%h err=%b want 8 ff fe 0",
                  lat, bus.Quotient, bus.Remainder, bus.error);
      end
      run_op(16'h0000, 8'h01, lat);
      total++;
      if (lat !== 8 || bus.Quotient !== 8'h00 || bus.Remainder !== 8'h00 || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL boundary_zero: got lat=%0d q=%h r=%h err=%b want 8 00 00 0",
                  lat, bus.Quotient, bus.Remainder, bus.error);
      end
   endtask

   task automatic test_fault;
      int lat;
      run_op(16'h1234, 8'h00, lat);
      total++;
      if (lat !== 1 || bus.Quotient !== 8'hFF || bus.Remainder !== 8'hFF || bus.error !== 1'b1) begin
         bad++;
         $display("FAIL fault_div0: got lat=%0d q=%h r=%h err=%b want 1 ff ff 1",
                  lat, bus.Quotient, bus.Remainder, bus.error);
      end
      run_op(16'h0800, 8'h08, lat);
      total++;
      if (lat !== 1 || bus.Quotient !== 8'hFF || bus.Remainder !== 8'hFF || bus.error !== 1'b1) begin
         bad++;
         $display("FAIL fault_ovf: got lat=%0d q=%h r=%h err=%b want 1 ff ff 1",
                  lat, bus.Quotient, bus.Remainder, bus.error);
      end
      run_op(16'h0064, 8'h0A, lat);
      total++;
      if (lat !== 8 || bus.Quotient !== 8'h0A || bus.Remainder !== 8'h00 || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL fault_clear: got lat=%0d q=%h r=%h err=%b want 8 0a 00 0",
                  lat, bus.Quotient, bus.Remainder, bus.error);
      end
   endtask

   task automatic test_busy_ignore;
      int lat;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.Dividend = 16'h03E8;
      bus.Divisor  = 8'h07;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.Dividend = {16{1'bx}};
      bus.Divisor  = {8{1'bx}};
      repeat (2) @(negedge clk);
      bus.start    = 1'b1;
      bus.Dividend = 16'h0064;
      bus.Divisor  = 8'h0A;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.Dividend = {16{1'bx}};
      bus.Divisor  = {8{1'bx}};
      lat = 3;
      while (bus.ready !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (lat !== 8 || bus.Quotient !== 8'h8E || bus.Remainder !== 8'h06 || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL busy_ignore: got lat=%0d q=%h r=%h err=%b want 8 8e 06 0",
                  lat, bus.Quotient, bus.Remainder, bus.error);
      end
   endtask

   task automatic test_abort;
      int lat;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.Dividend = 16'h03E8;
      bus.Divisor  = 8'h07;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.Dividend = {16{1'bx}};
      bus.Divisor  = {8{1'bx}};
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.ready !== 1'b1 || bus.Quotient !== 8'h00 || bus.Remainder !== 8'h00 || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL abort_reset: got rdy=%b q=%h r=%h err=%b want 1 00 00 0",
                  bus.ready, bus.Quotient, bus.Remainder, bus.error);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'h0064, 8'h0A, lat);
      total++;
      if (lat !== 8 || bus.Quotient !== 8'h0A || bus.Remainder !== 8'h00 || bus.error !== 1'b0) begin
         bad++;
         $display("FAIL abort_resume: got lat=%0d q=%h r=%h err=%b want 8 0a 00 0",
                  lat, bus.Quotient, bus.Remainder, bus.error);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.Dividend = 16'h03E8;
      bus.Divisor  = 8'h07;
      @(negedge clk);
      bus.Dividend = 16'h0064;
      bus.Divisor  = 8'h0A;
      lat = 0;
      while (bus.ready !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (lat !== 8 || bus.Quotient !== 8'h8E || bus.Remainder !== 8'h06) begin
         bad++;
         $display("FAIL b2b_first: got lat=%0d q=%h r=%h want 8 8e 06", lat, bus.Quotient, bus.Remainder);
      end
      @(negedge clk);
      total++;
      if (bus.ready !== 1'b0) begin
         bad++;
         $display("FAIL b2b_accept: got rdy=%b want 0", bus.ready);
      end
      bus.start    = 1'b0;
      bus.Dividend = {16{1'bx}};
      bus.Divisor  = {8{1'bx}};
      lat = 0;
      while (bus.ready !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (lat !== 8 || bus.Quotient !== 8'h0A || bus.Remainder !== 8'h00) begin
         bad++;
         $display("FAIL b2b_second: got lat=%0d q=%h r=%h want 8 0a 00", lat, bus.Quotient, bus.Remainder);
      end
   endtask

   task automatic test_random;
      int          lat;
      int          dvs_i;
      int          hi_i;
      int          lo_i;
      int          exp_q;
      int          exp_r;
      logic [15:0] dvd;
      logic [7:0]  dvs;
      for (int i = 0; i < 100; i++) begin
         dvs_i = int'($urandom_range(1, 255));
         hi_i  = int'($urandom_range(0, dvs_i - 1));
         lo_i  = int'($urandom_range(0, 255));
         dvs   = dvs_i[7:0];
         dvd   = {hi_i[7:0], lo_i[7:0]};
         exp_q = (hi_i * 256 + lo_i) / dvs_i;
         exp_r = (hi_i * 256 + lo_i) % dvs_i;
         run_op(dvd, dvs, lat);
         total++;
         if (lat !== 8 || bus.error !== 1'b0 || bus.Quotient !== exp_q[7:0] || bus.Remainder !== exp_r[7:0]) begin
            bad++;
            $display("FAIL random_%0d: %h/%h got lat=%0d q=%h r=%h err=%b want 8 %h %h 0",
                     i, dvd, dvs, lat, bus.Quotient, bus.Remainder, bus.error, exp_q[7:0], exp_r[7:0]);
         end else begin
            $display("random %0d OK: %h/%h = %h r %h", i, dvd, dvs, bus.Quotient, bus.Remainder);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset;
      test_nominal;
      test_boundary;
      test_fault;
      test_busy_ignore;
      test_abort;
      test_back_to_back;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
